// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake and scoreboard bundle between the ID stage and the hazard control.
// master drives the decoded instruction and retire bus; slave is the controller.
interface pipe_hazard_ctrl_if;
   logic        id_valid;
   logic [2:0]  id_rs;
   logic [2:0]  id_rt;
   logic        id_rs_used;
   logic        id_rt_used;
   logic [2:0]  id_rd;
   logic        id_regwrite;
   logic        id_memwrite;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic        flush;
   logic        id_ready;
   logic        ex_regwrite;
   logic        ex_memwrite;
   logic [7:0]  busy_mask;
   logic [1:0]  state;
   logic        err_underflow;
   logic [15:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
      output id_regwrite, id_memwrite, wb_valid, wb_rd, flush,
      input  id_ready, ex_regwrite, ex_memwrite, busy_mask, state,
      input  err_underflow, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
      input  id_regwrite, id_memwrite, wb_valid, wb_rd, flush,
      output id_ready, ex_regwrite, ex_memwrite, busy_mask, state,
      output err_underflow, stall_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based RAW/WAW hazard interlock with flush drain FSM.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] STALL = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0] r_pend [8];
   logic [1:0] r_state;
   logic       r_err;
   logic [1:0] w_next;
   logic [7:0] w_busy;
   logic       w_hazard;
   logic       w_ready;
   logic       w_issue;
   logic       w_inc;
   logic       w_dec;
   logic       w_same;

   always_comb begin
      w_busy = 8'h00;
      for (int i = 0; i < 8; i++) w_busy[i] = (r_pend[i] != 2'd0);
   end

   assign w_hazard = (bus.id_rs_used && r_pend[bus.id_rs] != 2'd0)
                   | (bus.id_rt_used && r_pend[bus.id_rt] != 2'd0)
                   | (bus.id_regwrite && r_pend[bus.id_rd] == 2'd3);
   assign w_ready  = (r_state == RUN) & ~w_hazard & ~bus.flush;
   assign w_issue  = bus.id_valid & w_ready;
   assign w_inc    = w_issue & bus.id_regwrite;
   assign w_dec    = bus.wb_valid;
   // a write issued and retired to one register in the same cycle cancels out
   assign w_same   = w_inc & w_dec & (bus.id_rd == bus.wb_rd);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) r_pend[i] <= 2'd0;
      end else if (!w_same) begin
         for (int i = 0; i < 8; i++) begin
            if (w_inc && bus.id_rd == 3'(i))
               r_pend[i] <= r_pend[i] + 2'd1;
            else if (w_dec && bus.wb_rd == 3'(i) && r_pend[i] != 2'd0)
               r_pend[i] <= r_pend[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_err <= 1'b0;
      else if (w_dec && !w_same && r_pend[bus.wb_rd] == 2'd0)
         r_err <= 1'b1;
   end

   always_comb begin
      w_next = r_state;
      if (bus.flush) begin
         w_next = DRAIN;
      end else begin
         case (r_state)
            IDLE:    if (bus.id_valid) w_next = RUN;
            RUN:     if (!bus.id_valid) w_next = IDLE;
                     else if (w_hazard) w_next = STALL;
            STALL:   if (!w_hazard) w_next = RUN;
            DRAIN:   if (w_busy == 8'h00) w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= 16'h0000;
      else if (bus.id_valid && !w_ready && !bus.flush && r_stall_cnt != 16'hFFFF)
         r_stall_cnt <= r_stall_cnt + 16'h0001;
   end

   assign bus.stall_count = r_stall_cnt;
`else
   assign bus.stall_count = 16'h0000;
`endif

   assign bus.id_ready      = w_ready;
   assign bus.ex_regwrite   = w_issue & bus.id_regwrite;
   assign bus.ex_memwrite   = w_issue & bus.id_memwrite;
   assign bus.busy_mask     = w_busy;
   assign bus.state         = r_state;
   assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Expected values are hand-derived per step.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0;
      bus.id_rs_used = 0; bus.id_rt_used = 0; bus.id_rd = 0;
      bus.id_regwrite = 0; bus.id_memwrite = 0;
      bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0;
   endtask

   task automatic instr(input logic [2:0] rd, input logic rw,
                        input logic mw, input logic [2:0] rs,
                        input logic rs_u);
      bus.id_valid = 1; bus.id_rd = rd; bus.id_regwrite = rw;
      bus.id_memwrite = mw; bus.id_rs = rs; bus.id_rs_used = rs_u;
   endtask

   task automatic wb(input logic v, input logic [2:0] rd);
      bus.wb_valid = v; bus.wb_rd = rd;
   endtask

   logic [15:0] exp_cnt;

   initial begin
`ifdef HAZARD_STALL_CNT_EN
      exp_cnt = 16'd5;
`else
      exp_cnt = 16'd0;
`endif
      clr();
      #2;
      chk("rst_ready", 16'(bus.id_ready), 16'd0);
      chk("rst_state", 16'(bus.state), 16'd0);
      chk("rst_busy", 16'(bus.busy_mask), 16'h00);
      chk("rst_err", 16'(bus.err_underflow), 16'd0);
      chk("rst_cnt", bus.stall_count, 16'd0);
      cyc();
      reset = 1;
      cyc();

      // RAW stall on r3
      instr(3'd3, 1, 0, 3'd0, 0);
      #1 chk("idle_noready", 16'(bus.id_ready), 16'd0);
      cyc();
      chk("run_state", 16'(bus.state), 16'd1);
      chk("issue_rw", 16'(bus.ex_regwrite), 16'd1);
      cyc();
      chk("busy_r3", 16'(bus.busy_mask), 16'h08);
      instr(3'd0, 0, 1, 3'd3, 1);
      #1 chk("raw_ready", 16'(bus.id_ready), 16'd0);
      chk("raw_bubble_mw", 16'(bus.ex_memwrite), 16'd0);
      cyc();
      chk("stall_state", 16'(bus.state), 16'd2);
      wb(1, 3'd3);
      cyc();
      wb(0, 3'd0);
      chk("r3_retired", 16'(bus.busy_mask), 16'h00);
      chk("stall_hold", 16'(bus.state), 16'd2);
      cyc();
      chk("unstall_state", 16'(bus.state), 16'd1);
      chk("unstall_issue", 16'(bus.ex_memwrite), 16'd1);
      cyc();
      clr();
      cyc();
      chk("back_idle", 16'(bus.state), 16'd0);

      // WAW saturation on r5
      instr(3'd5, 1, 0, 3'd0, 0);
      cyc();
      cyc();
      cyc();
      cyc();
      chk("r5_busy", 16'(bus.busy_mask), 16'h20);
      chk("r5_full_ready", 16'(bus.id_ready), 16'd0);
      cyc();
      chk("r5_stall", 16'(bus.state), 16'd2);
      wb(1, 3'd5);
      cyc();
      wb(0, 3'd0);
      chk("r5_still_stall", 16'(bus.id_ready), 16'd0);
      cyc();
      chk("r5_resume", 16'(bus.id_ready), 16'd1);

      // same-cycle issue and retire on r2; also drain r5
      instr(3'd2, 1, 0, 3'd0, 0);
      wb(1, 3'd5);
      cyc();
      wb(1, 3'd2);
      #1 chk("r2_ready", 16'(bus.id_ready), 16'd1);
      cyc();
      chk("r2_cancel", 16'(bus.busy_mask), 16'h24);
      clr();
      wb(1, 3'd5);
      cyc();
      cyc();
      chk("r5_clear", 16'(bus.busy_mask), 16'h04);
      chk("idle_again", 16'(bus.state), 16'd0);

      // underflow on r6
      wb(1, 3'd6);
      cyc();
      chk("uf_busy", 16'(bus.busy_mask), 16'h04);
      chk("uf_err", 16'(bus.err_underflow), 16'd1);
      wb(0, 3'd0);
      cyc();
      chk("uf_sticky", 16'(bus.err_underflow), 16'd1);

      // flush and drain with r1 twice pending
      instr(3'd1, 1, 0, 3'd0, 0);
      cyc();
      cyc();
      cyc();
      chk("r1_busy", 16'(bus.busy_mask), 16'h06);
      bus.flush = 1;
      #1 chk("flush_ready", 16'(bus.id_ready), 16'd0);
      chk("flush_bubble", 16'(bus.ex_regwrite), 16'd0);
      cyc();
      chk("drain_state", 16'(bus.state), 16'd3);
      bus.flush = 0;
      wb(1, 3'd1);
      #1 chk("drain_ready", 16'(bus.id_ready), 16'd0);
      cyc();
      cyc();
      wb(1, 3'd2);
      cyc();
      chk("drain_busy0", 16'(bus.busy_mask), 16'h00);
      chk("drain_hold", 16'(bus.state), 16'd3);
      clr();
      bus.flush = 1;
      cyc();
      chk("reflush_drain", 16'(bus.state), 16'd3);
      bus.flush = 0;
      cyc();
      chk("drain_idle", 16'(bus.state), 16'd0);

      // stall counter and asynchronous reset mid-stall
      reset = 0;
      #2 reset = 1;
      cyc();
      chk("rst2_err", 16'(bus.err_underflow), 16'd0);
      instr(3'd4, 1, 0, 3'd0, 0);
      cyc();
      cyc();
      instr(3'd0, 0, 0, 3'd4, 1);
      cyc();
      cyc();
      cyc();
      cyc();
      chk("stall_cnt", bus.stall_count, exp_cnt);
      chk("mid_state", 16'(bus.state), 16'd2);
      #2 reset = 0;
      #1;
      chk("arst_state", 16'(bus.state), 16'd0);
      chk("arst_busy", 16'(bus.busy_mask), 16'h00);
      chk("arst_ready", 16'(bus.id_ready), 16'd0);
      chk("arst_cnt", bus.stall_count, 16'd0);
      chk("arst_ex", 16'({bus.ex_regwrite, bus.ex_memwrite}), 16'd0);
      #2 reset = 1;
      cyc();
      chk("post_busy", 16'(bus.busy_mask), 16'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have clk, input, 1, pipeline clock; all state updates on rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous, active-low; clears all state.
REQ-003 SHALL have id_valid, input, 1, ID stage holds a decoded instruction.
REQ-004 SHALL have id_rs / id_rt, input, 3 each, source register addresses.
REQ-005 SHALL have id_rs_used / id_rt_used, input, 1 each, source operand actually read.
REQ-006 SHALL have id_rd, input, 3, destination register address.
REQ-007 SHALL have id_regwrite / id_memwrite, input, 1 each, decoded control bits.
REQ-008 SHALL have wb_valid, input, 1, a register write retires this cycle; wb_rd, input, 3, its address.
REQ-009 SHALL have flush, input, 1, single-cycle drain request.
REQ-010 SHALL have id_ready, output, 1, instruction accepted this cycle; issue = id_valid & id_ready.
REQ-011 SHALL have ex_regwrite / ex_memwrite, output, 1 each, gated control into the ID/EX register; 0 = bubble.
REQ-012 SHALL have busy_mask, output, 8, bit n set when register n has a pending write.
REQ-013 SHALL have state, output, 2, encoded FSM state; err_underflow, output, 1, sticky error.
REQ-014 SHALL have stall_count, output, 16, count of stalled cycles (see Configuration).

Function
REQ-015 SHALL keep per-register 2-bit pending-write counters pend[0..7]; busy_mask[n] = (pend[n] != 0).
REQ-016 SHALL define hazard = (id_rs_used & pend[id_rs]!=0) | (id_rt_used & pend[id_rt]!=0) | (id_regwrite & pend[id_rd]==3).
REQ-017 SHALL drive id_ready combinationally = (state==RUN) & ~hazard & ~flush.
REQ-018 SHALL drive ex_regwrite = issue & id_regwrite and ex_memwrite = issue & id_memwrite; any non-issue cycle is a bubble (both 0).
REQ-019 SHALL increment pend[id_rd] on the edge after an issue with id_regwrite=1.
REQ-020 SHALL decrement pend[wb_rd] on the edge after wb_valid=1.
REQ-021 SHALL leave pend unchanged when increment and decrement target the same register on the same cycle.
REQ-022 SHALL ignore a decrement of a zero counter and set err_underflow (sticky until reset).
REQ-023 SHALL implement FSM states IDLE=0, RUN=1, STALL=2, DRAIN=3.
REQ-024 IDLE -> RUN when id_valid=1; RUN -> IDLE when id_valid=0; RUN -> STALL when id_valid & hazard; STALL -> RUN on the first cycle hazard=0.
REQ-025 Issue SHALL occur only in RUN; the first cycle after leaving STALL or IDLE issues the held instruction with no additional delay beyond the transition edge.
REQ-026 flush=1 in any state SHALL force DRAIN on the next edge and a bubble in the same cycle (flush has priority over issue).
REQ-027 DRAIN SHALL hold id_ready=0 until busy_mask==0, then go to IDLE; retirements continue during DRAIN.
REQ-028 flush while already in DRAIN SHALL keep DRAIN with no other effect.

Reset
REQ-029 On reset low: pend all 0, busy_mask=0, state=IDLE, err_underflow=0, stall_count=0; ex_regwrite/ex_memwrite=0 and id_ready=0 while reset low.
REQ-030 Reset mid-operation SHALL discard all pending-write tracking immediately; no retire is required afterward.

Configuration
REQ-031 Macro HAZARD_STALL_CNT_EN defined: stall_count increments (saturating at 16'hFFFF) each cycle with id_valid=1, id_ready=0, and flush=0.
REQ-032 Macro HAZARD_STALL_CNT_EN undefined: counter logic absent, stall_count tied to 16'h0000; all other behaviour identical.

Verification
REQ-033 Issue rd=3 regwrite, next cycle rs=3 used -> id_ready=0, state=STALL, bubble; wb_valid rd=3 -> pend[3]=0, issue on next cycle, state=RUN.
REQ-034 Three back-to-back issues to rd=5 -> pend[5]=3; fourth write to rd=5 stalls until one wb_valid rd=5.
REQ-035 Same-cycle issue rd=2 and wb_valid rd=2 with pend[2]=1 -> pend[2] stays 1, busy_mask=8'h04.
REQ-036 wb_valid rd=6 with pend[6]=0 -> pend unchanged, err_underflow=1 and stays 1.
REQ-037 pend[1]=2, flush pulse with id_valid=1 -> bubble that cycle, DRAIN for two retirements, then IDLE, busy_mask=0.
REQ-038 With HAZARD_STALL_CNT_EN, 5 stalled cycles -> stall_count=5; reset low mid-stall -> all outputs at reset values within the same cycle.
